db15_joy_responder: RTL
=======================

// Module: db15_joy_responder
// PURPOSE
//  Device-side end of the DB15 serial joystick link: emulates the 2-player adapter's 74HC165 chain.
//  Samples two 16-bit player words on JOY_LOAD low and shifts them out on JOY_DATA per JOY_CLK rising edge.
//  Drives bench/loopback rigs and a pass-through adapter core; pairs with the joy_db15 receiver.
//  Wire level is active-low (pressed = 0); joystick inputs are active-high.
// PARAMETERS
//  FRAME_BITS   32  bits per frame: player1 word[15:0] then player2 word[15:0]; must be 2..32.
//  SYNC_STAGES  2   flip-flop depth of the JOY_CLK/JOY_LOAD input synchronisers; must be >=2.
// PORTS
//  clk           in   1   system clock, 40-50 MHz; all state on posedge.
//  reset         in   1   asynchronous, active-high; clears all state.
//  joystick1     in   16  player1 bits, active-high: 0 R, 1 L, 2 D, 3 U, 4..9 A,B,C,X,Y,Z, 10 start, 11 select/coin.
//  joystick2     in   16  player2, same layout.
//  JOY_LOAD      in   1   async from host; low = parallel load (load dominates clk).
//  JOY_CLK       in   1   async from host; each rising edge shifts one bit.
//  JOY_DATA      out  1   serial data, active-low, registered.
//  frame_done    out  1   1-cycle pulse when bit FRAME_BITS-1 has been presented.
//  frame_count   out  16  frames completed (stats build only; else 0).
//  short_frame   out  1   sticky: load seen mid-frame (stats build only; else 0).
// BEHAVIOUR
//  Reset values: shift reg all 1s, JOY_DATA=1, frame_done=0, frame_count=0, short_frame=0, state IDLE.
//  Synchronisers: SYNC_STAGES FFs per input, flops preset to 1. Edges come from the last stage vs a delay reg.
//  Load: while sync load=0, every cycle shift_reg <= ~{joystick2,joystick1} (p1 bit0 at the output end).
//    Bit count resets to 0 and JOY_DATA <= ~joystick1[0]. Clock edges are ignored while load=0.
//  Shift: on a sync JOY_CLK rising edge with load=1: shift toward the output, fill with 1, bit_cnt+1.
//    JOY_DATA is updated the cycle after the edge is detected.
//  Latency: pin edge -> JOY_DATA change is SYNC_STAGES+2 clk cycles (4 at default). The host must sample >=100 ns after its edge.
//  FSM states: IDLE (after reset, no load yet; JOY_DATA=1), LOADED (load low), SHIFT (bit_cnt<FRAME_BITS), DONE (bits exhausted).
//    IDLE->LOADED on load=0. LOADED->SHIFT on load rising.
//    SHIFT->DONE when bit_cnt reaches FRAME_BITS-1, with frame_done pulsed in the same cycle.
//    DONE: further clk edges shift out 1s; bit_cnt saturates. Any state->LOADED on load=0.
//  Boundaries:
//    Load falling in SHIFT: immediate reload and restart; counts as a short frame.
//    Load and clk edges in the same cycle: load wins.
//    Inputs change during SHIFT: no effect until the next load.
//    FRAME_BITS<32: the upper bits of {joystick2,joystick1} are never presented.
//    Reset mid-frame: async clear to the reset values; the next frame requires a fresh load.
// CONFIGURATION
//  Macro DB15_RESP_STATS_EN, when defined:
//    frame_count increments on each frame_done and wraps at 0xFFFF.
//    short_frame sets on a load entry from SHIFT with bit_cnt>0; only reset clears it.
//  Undefined: frame_count and short_frame are tied to 0 and no counter logic is built. Ports exist in both builds.
// STRUCTURE
//  Package db15_pkg: typedef enum logic[1:0] {IDLE,LOADED,SHIFT,DONE} db15_state_t.
//    It also holds bit-index localparams (DB15_R=0 ... DB15_COIN=11) and DB15_WORD_W=16.
//  Sub-module sync_bit: SYNC_STAGES-deep synchroniser with preset-to-1 and async reset; two instances.
//  Top: edge detect, FSM, shift register and bit counter, plus the optional stats block.
// TESTING
//  T1 j1=16'h0001, j2=16'h0800; load pulse then 32 clk edges.
//    JOY_DATA bit0=0, bits1..26=1, bit27=0, rest=1; frame_done pulses once after bit 31.
//  T2 Load held low 10 cycles while j1 changes 0x0000->0x00FF.
//    Shifted frame reflects 0x00FF: first 8 bits 0, remaining 24 bits 1.
//  T3 Load falls after 5 edges with j1=16'h0010.
//    Restart: JOY_DATA=1 (bit0); with stats, short_frame=1 and frame_count is unchanged.
//  T4 Load low in the same cycle as a clk edge.
//    No shift occurs; bit_cnt=0 after load rises.
//  T5 34 clk edges after load.
//    Edges 33 and 34 give JOY_DATA=1; frame_done pulses once; with stats, frame_count=1.
//  T6 Reset asserted mid-frame, then released.
//    JOY_DATA=1 immediately and state IDLE; clk edges without a load keep JOY_DATA=1.

Source files
------------

// File: rtl/db15_pkg.sv
// DB15 joystick link: shared state encoding, button bit positions and word width.
package db15_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOADED = 2'd1,
      SHIFT  = 2'd2,
      DONE   = 2'd3
   } db15_state_t;

   localparam int DB15_WORD_W = 16;

   localparam int DB15_R      = 0;
   localparam int DB15_L      = 1;
   localparam int DB15_D      = 2;
   localparam int DB15_U      = 3;
   localparam int DB15_A      = 4;
   localparam int DB15_B      = 5;
   localparam int DB15_C      = 6;
   localparam int DB15_X      = 7;
   localparam int DB15_Y      = 8;
   localparam int DB15_Z      = 9;
   localparam int DB15_START  = 10;
   localparam int DB15_COIN   = 11;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for one asynchronous host line. The flops preset to 1
// so an idle (high) host line produces no spurious edge when reset releases.
module sync_bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] sync_ff;

   // Shift the raw line through the flop chain; the last stage is the safe copy
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_ff <= '1;
      end else begin
         sync_ff <= {sync_ff[SYNC_STAGES-2:0], d};
      end
   end

   assign q = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/db15_joy_responder.sv
// Device side of the DB15 serial joystick link: behaves like the 2-player
// adapter's 74HC165 chain. Player words are latched while JOY_LOAD is low and
// shifted out (active-low) one bit per JOY_CLK rising edge.
// Optional statistics (frame_count, short_frame) are built only when the
// macro DB15_RESP_STATS_EN is defined; otherwise both outputs are tied to 0.
module db15_joy_responder
   import db15_pkg::*;
#(
   parameter int FRAME_BITS  = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [DB15_WORD_W-1:0] joystick1,
   input  logic [DB15_WORD_W-1:0] joystick2,
   input  logic                   JOY_LOAD,
   input  logic                   JOY_CLK,
   output logic                   JOY_DATA,
   output logic                   frame_done,
   output logic [15:0]            frame_count,
   output logic                   short_frame
);

   localparam int CNT_W = $clog2(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_LAST_M1 = CNT_W'(FRAME_BITS - 2);

   logic                      load_sync;
   logic                      clk_sync;
   logic                      clk_sync_p1;
   logic                      clk_rise;
   logic                      shift_en;
   logic [2*DB15_WORD_W-1:0]  load_word;
   logic [FRAME_BITS-1:0]     shift_reg;
   logic [CNT_W-1:0]          bit_cnt;
   logic                      joy_data_q;
   db15_state_t               state;

   sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_load (
      .clk   (clk),
      .reset (reset),
      .d     (JOY_LOAD),
      .q     (load_sync)
   );

   sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_clk (
      .clk   (clk),
      .reset (reset),
      .d     (JOY_CLK),
      .q     (clk_sync)
   );

   // Delay copy of the synchronised clock line for rising-edge detection
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         clk_sync_p1 <= 1'b1;
      end else begin
         clk_sync_p1 <= clk_sync;
      end
   end

   assign clk_rise  = clk_sync & ~clk_sync_p1;
   // Wire level is active-low; player1 bit0 sits at the output end
   assign load_word = ~{joystick2, joystick1};
   // Edges only move data once a load has been released; IDLE/LOADED drop them
   assign shift_en  = clk_rise && load_sync && (state == SHIFT || state == DONE);

   // Frame FSM and bit counter; a low load always restarts the frame
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         bit_cnt    <= '0;
         frame_done <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (!load_sync) begin
            state   <= LOADED;
            bit_cnt <= '0;
         end else begin
            case (state)
               LOADED: state <= SHIFT;
               SHIFT: begin
                  if (clk_rise) begin
                     bit_cnt <= bit_cnt + 1'b1;
                     if (bit_cnt == CNT_LAST_M1) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                     end
                  end
               end
               default: state <= state;
            endcase
         end
      end
   end

   // Shift register and output pin: load overrides, otherwise fill with idle 1s
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shift_reg  <= '1;
         joy_data_q <= 1'b1;
      end else if (!load_sync) begin
         shift_reg  <= load_word[FRAME_BITS-1:0];
         joy_data_q <= ~joystick1[0];
      end else begin
         joy_data_q <= shift_reg[0];
         if (shift_en) begin
            shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
         end
      end
   end

   assign JOY_DATA = joy_data_q;

`ifdef DB15_RESP_STATS_EN
   logic [15:0] frame_count_q;
   logic        short_frame_q;

   // Frame statistics: completed-frame counter and sticky truncated-frame flag
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_count_q <= '0;
         short_frame_q <= 1'b0;
      end else begin
         if (frame_done) begin
            frame_count_q <= frame_count_q + 16'd1;
         end
         if (!load_sync && state == SHIFT && bit_cnt != '0) begin
            short_frame_q <= 1'b1;
         end
      end
   end

   assign frame_count = frame_count_q;
   assign short_frame = short_frame_q;
`else
   assign frame_count = '0;
   assign short_frame = 1'b0;
`endif

endmodule
